riscv_hwloop_unit: RTL

- Holds the zero-overhead hardware-loop register sets (start, end, count) written through the CSR write port.
- Watches the PC of each instruction as it completes in ID. At a loop end it decrements the count and issues a redirect to the loop start.
- Returns all register values to the CSR block for reads (0x7B0–0x7B6).
- Sits downstream of the CSR block and beside the ID/IF stages.

---
 rtl/riscv_hwloop_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/riscv_hwloop_unit.sv
// riscv_hwloop_unit
// Zero-overhead hardware-loop register sets (start, end, count). The CSR
// write port loads the registers. When the instruction in ID completes at a
// loop end, the unit decrements the count and redirects fetch to the loop
// start. All register values are exported so the CSR block can read them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   hwlp_we_i[2:0]      CSR write strobes: bit0 start, bit1 end, bit2 count
//   hwlp_regid_i        register set targeted by the CSR write
//   hwlp_data_i         CSR write data
//   current_pc_i        PC of the instruction in ID
//   instr_valid_i       instruction at current_pc_i completes ID this cycle
//   pc_set_i            branch/jump/exception redirect this cycle
//   hwlp_jump_o         redirect fetch to hwlp_targ_addr_o (combinational)
//   hwlp_targ_addr_o    start address of the acting set
//   hwlp_start_o/end_o/cnt_o  register sets, set i at bits [32i+31:32i]
module riscv_hwloop_unit #(
    parameter int N_REGSETS = 2,
    parameter int REGID_W   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              hwlp_we_i,
    input  logic [REGID_W-1:0]      hwlp_regid_i,
    input  logic [31:0]             hwlp_data_i,
    input  logic [31:0]             current_pc_i,
    input  logic                    instr_valid_i,
    input  logic                    pc_set_i,
    output logic                    hwlp_jump_o,
    output logic [31:0]             hwlp_targ_addr_o,
    output logic [32*N_REGSETS-1:0] hwlp_start_o,
    output logic [32*N_REGSETS-1:0] hwlp_end_o,
    output logic [32*N_REGSETS-1:0] hwlp_cnt_o
);

    logic [31:0]          start_q [N_REGSETS];
    logic [31:0]          start_d [N_REGSETS];
    logic [31:0]          end_q   [N_REGSETS];
    logic [31:0]          end_d   [N_REGSETS];
    logic [31:0]          cnt_q   [N_REGSETS];
    logic [31:0]          cnt_d   [N_REGSETS];
    logic [N_REGSETS-1:0] match;
    logic                 acted;

    // A set with cnt == 0 is inactive and never matches.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_REGSETS; i++) begin
            match[i] = (cnt_q[i] != 32'd0) && (current_pc_i == end_q[i]);
        end
    end

    // Walk sets from the innermost outward. Matching sets on their final
    // iteration (cnt == 1) fall through to 0. The first matching set that
    // still has iterations left takes the jump. Outer sets are left alone.
    always_comb begin
        hwlp_jump_o      = 1'b0;
        hwlp_targ_addr_o = 32'd0;
        acted            = 1'b0;
        start_d          = start_q;
        end_d            = end_q;
        cnt_d            = cnt_q;

        if (instr_valid_i && !pc_set_i) begin
            for (int i = 0; i < N_REGSETS; i++) begin
                if (!acted && match[i]) begin
                    if (cnt_q[i] > 32'd1) begin
                        cnt_d[i]         = cnt_q[i] - 32'd1;
                        hwlp_jump_o      = 1'b1;
                        hwlp_targ_addr_o = start_q[i];
                        acted            = 1'b1;
                    end else begin
                        cnt_d[i] = 32'd0;
                    end
                end
            end
        end

        // CSR writes come after the loop updates, so a count write overrides
        // a same-cycle decrement. The jump target above already used the old
        // start. An out-of-range regid matches no set.
        for (int i = 0; i < N_REGSETS; i++) begin
            if (hwlp_regid_i == REGID_W'(i)) begin
                if (hwlp_we_i[0]) start_d[i] = hwlp_data_i;
                if (hwlp_we_i[1]) end_d[i]   = hwlp_data_i;
                if (hwlp_we_i[2]) cnt_d[i]   = hwlp_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '{default: '0};
            end_q   <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < N_REGSETS; g++) begin : g_out
        assign hwlp_start_o[32*g +: 32] = start_q[g];
        assign hwlp_end_o[32*g +: 32]   = end_q[g];
        assign hwlp_cnt_o[32*g +: 32]   = cnt_q[g];
    end

endmodule
